// File: rtl/ne_dec_pkg.sv
// rtl/ne_dec_pkg.sv - shared decoder constants and load/unload state encoding
package ne_dec_pkg;

    localparam int ROWDEPTH    = 20;
    localparam int ROWWIDTH    = 5;
    localparam int DW          = 208;
    localparam int MEMRDCYCLES = 2;
    localparam int FIFO_DEPTH  = MEMRDCYCLES + 2;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_DECODE = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

endpackage

// File: rtl/ne_skid_fifo.sv
// rtl/ne_skid_fifo.sv - small synchronous FIFO absorbing hard-decision read latency
module ne_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 208,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer, occupancy and storage updates for one push and/or one pop
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; emptying pointers discards contents
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ne_loadunload_ctrl.sv
// rtl/ne_loadunload_ctrl.sv - codeword load into Lmem, decode handoff and hard-decision unload
module ne_loadunload_ctrl #(
    parameter int ROWDEPTH    = ne_dec_pkg::ROWDEPTH,
    parameter int ROWWIDTH    = ne_dec_pkg::ROWWIDTH,
    parameter int DW          = ne_dec_pkg::DW,
    parameter int MEMRDCYCLES = ne_dec_pkg::MEMRDCYCLES,
    parameter int FIFO_DEPTH  = MEMRDCYCLES + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    output logic                lmem_wr_en,
    output logic [ROWWIDTH-1:0] lmem_wr_addr,
    output logic [DW-1:0]       lmem_wdata,
    output logic                loaden,
    output logic                start,
    input  logic                SISOready,
    output logic                hd_rd_en,
    output logic [ROWWIDTH-1:0] hd_rd_addr,
    input  logic [DW-1:0]       hd_rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err
);

    import ne_dec_pkg::state_e;
    import ne_dec_pkg::ST_LOAD;
    import ne_dec_pkg::ST_START;
    import ne_dec_pkg::ST_DECODE;
    import ne_dec_pkg::ST_UNLOAD;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [ROWWIDTH-1:0] LAST_ROW = ROWWIDTH'(ROWDEPTH - 1);

    state_e                 state_q, state_d;
    logic [ROWWIDTH-1:0]    load_cnt_q, load_cnt_d;
    logic                   lmem_wr_en_q, lmem_wr_en_d;
    logic [ROWWIDTH-1:0]    lmem_wr_addr_q, lmem_wr_addr_d;
    logic [DW-1:0]          lmem_wdata_q, lmem_wdata_d;
    logic                   frame_err_q, frame_err_d;
    logic                   frame_done_q, frame_done_d;
    logic [ROWWIDTH-1:0]    rd_cnt_q, rd_cnt_d;
    logic                   rd_done_q, rd_done_d;
    logic [ROWWIDTH-1:0]    out_cnt_q, out_cnt_d;
    logic [MEMRDCYCLES-1:0] vld_sr_q, vld_sr_d;

    logic                   in_fire;
    logic                   out_fire;
    logic                   rd_room;
    logic [OW-1:0]          inflight;
    logic [OW-1:0]          occupancy;
    logic                   fifo_push;
    logic                   fifo_empty;
    logic [DW-1:0]          fifo_head;
    logic [CW-1:0]          fifo_count;

    assign in_ready     = (state_q == ST_LOAD);
    assign in_fire      = in_valid & in_ready;
    assign loaden       = (state_q == ST_LOAD) | lmem_wr_en_q;
    // The decoder must not start while the final Lmem write is still landing
    assign start        = (state_q == ST_START) & ~lmem_wr_en_q;
    assign lmem_wr_en   = lmem_wr_en_q;
    assign lmem_wr_addr = lmem_wr_addr_q;
    assign lmem_wdata   = lmem_wdata_q;
    assign busy         = (state_q != ST_LOAD) | (load_cnt_q != '0);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

    // Reads are only issued when every in-flight row is guaranteed a FIFO slot
    assign hd_rd_en     = (state_q == ST_UNLOAD) & ~rd_done_q & rd_room;
    assign hd_rd_addr   = rd_cnt_q;
    assign fifo_push    = vld_sr_q[MEMRDCYCLES-1];

    assign out_valid    = ~fifo_empty;
    assign out_data     = out_valid ? fifo_head : '0;
    assign out_fire     = out_valid & out_ready;
    assign out_last     = out_valid & (out_cnt_q == LAST_ROW);

    // Rows requested but not yet captured, plus rows already buffered
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEMRDCYCLES; i++) begin
            inflight = inflight + {{CW{1'b0}}, vld_sr_q[i]};
        end
        occupancy = inflight + {1'b0, fifo_count};
        rd_room   = (occupancy < OW'(FIFO_DEPTH));
    end

    // Next-state and counter logic for the load / start / decode / unload cycle
    always_comb begin
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        lmem_wr_en_d   = 1'b0;
        lmem_wr_addr_d = lmem_wr_addr_q;
        lmem_wdata_d   = lmem_wdata_q;
        frame_err_d    = 1'b0;
        frame_done_d   = 1'b0;
        rd_cnt_d       = rd_cnt_q;
        rd_done_d      = rd_done_q;
        out_cnt_d      = out_cnt_q;
        vld_sr_d       = (vld_sr_q << 1) | MEMRDCYCLES'(hd_rd_en);

        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    lmem_wr_en_d   = 1'b1;
                    lmem_wr_addr_d = load_cnt_q;
                    lmem_wdata_d   = in_data;
                    if (load_cnt_q == LAST_ROW) begin
                        // Row count alone completes the frame; a missing in_last is only flagged
                        load_cnt_d  = '0;
                        frame_err_d = ~in_last;
                        state_d     = ST_START;
                    end else if (in_last) begin
                        // Short frame: discard and restart loading from row 0
                        load_cnt_d  = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + ROWWIDTH'(1);
                    end
                end
            end
            ST_START: begin
                if (start) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (SISOready) begin
                    state_d   = ST_UNLOAD;
                    rd_cnt_d  = '0;
                    rd_done_d = 1'b0;
                    out_cnt_d = '0;
                end
            end
            ST_UNLOAD: begin
                if (hd_rd_en) begin
                    if (rd_cnt_q == LAST_ROW) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ROWWIDTH'(1);
                    end
                end
                if (out_fire) begin
                    if (out_last) begin
                        state_d      = ST_LOAD;
                        frame_done_d = 1'b1;
                        rd_cnt_d     = '0;
                        rd_done_d    = 1'b0;
                        out_cnt_d    = '0;
                    end else begin
                        out_cnt_d = out_cnt_q + ROWWIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and counters; reset also drops any read data still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_LOAD;
            load_cnt_q     <= '0;
            lmem_wr_en_q   <= 1'b0;
            lmem_wr_addr_q <= '0;
            lmem_wdata_q   <= '0;
            frame_err_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            rd_cnt_q       <= '0;
            rd_done_q      <= 1'b0;
            out_cnt_q      <= '0;
            vld_sr_q       <= '0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            lmem_wr_en_q   <= lmem_wr_en_d;
            lmem_wr_addr_q <= lmem_wr_addr_d;
            lmem_wdata_q   <= lmem_wdata_d;
            frame_err_q    <= frame_err_d;
            frame_done_q   <= frame_done_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_done_q      <= rd_done_d;
            out_cnt_q      <= out_cnt_d;
            vld_sr_q       <= vld_sr_d;
        end
    end

    ne_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (hd_rd_data),
        .pop       (out_fire),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/ne_loadunload_ctrl.md
NE_LOADUNLOAD_CTRL -- requirements
Module: ne_loadunload_ctrl

Interface
REQ-001 Parameter: ROWDEPTH, 20, Lmem rows per codeword (Z/P).
REQ-002 Parameter: ROWWIDTH, 5, row-address width (2**ROWWIDTH >= ROWDEPTH).
REQ-003 Parameter: DW, 208, row data width (P x 8-bit LLR).
REQ-004 Parameter: MEMRDCYCLES, 2, hard-decision memory read latency in cycles (>=1).
REQ-005 Parameter: FIFO_DEPTH, MEMRDCYCLES+2, output skid buffer depth.
REQ-006 Port: clk  in  1  single clock; all logic rising-edge.
REQ-007 Port: rst  in  1  reset, synchronous, active-high.
REQ-008 Ports: in_valid in 1, in_ready out 1, in_data in DW, in_last in 1 -- codeword input stream, one row per beat.
REQ-009 Ports: lmem_wr_en out 1, lmem_wr_addr out ROWWIDTH, lmem_wdata out DW -- Lmem load write port.
REQ-010 Ports: loaden out 1, start out 1 -- to decoder address-generator FSM; SISOready in 1 -- decode-complete level from it.
REQ-011 Ports: hd_rd_en out 1, hd_rd_addr out ROWWIDTH, hd_rd_data in DW -- hard-decision memory read port.
REQ-012 Ports: out_valid out 1, out_ready in 1, out_data out DW, out_last out 1 -- decoded output stream.
REQ-013 Ports: busy out 1, frame_done out 1 (pulse), frame_err out 1 (pulse).

Function
REQ-014 FSM states LOAD (reset state), START, DECODE, UNLOAD; one frame at a time, no overlap.
REQ-015 LOAD: in_ready=1; each handshake (in_valid&in_ready) increments load counter 0..ROWDEPTH-1 and registers one write: lmem_wr_en=1, lmem_wr_addr=counter, lmem_wdata=in_data, next cycle (latency 1).
REQ-016 Handshake on counter==ROWDEPTH-1 -> START next cycle, counter cleared; in_last ignored for completion.
REQ-017 in_last=1 on beat with counter<ROWDEPTH-1 -> frame_err one-cycle pulse, counter cleared, stay LOAD (frame discarded); in_last=0 on final beat -> frame_err pulse, frame still proceeds.
REQ-018 loaden = (state==LOAD) | lmem_wr_en; start never asserted while loaden=1.
REQ-019 START: start = !lmem_wr_en (exactly one cycle high); transition to DECODE in the cycle start=1; in_ready=0 in all states except LOAD.
REQ-020 DECODE: wait SISOready==1 -> UNLOAD; SISOready sampled only in DECODE.
REQ-021 UNLOAD: read counter 0..ROWDEPTH-1 at hd_rd_addr; hd_rd_en=1 only if outstanding_reads + fifo_count < FIFO_DEPTH and reads remain.
REQ-022 hd_rd_data captured into skid FIFO exactly MEMRDCYCLES cycles after hd_rd_en, tracked by internal valid shift register; FIFO never overflows.
REQ-023 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&out_ready; out_last=1 on ROWDEPTH-th output beat only.
REQ-024 With out_ready held 1, throughput one row per cycle; first out_valid MEMRDCYCLES+1 cycles after UNLOAD entry.
REQ-025 out_valid/out_data held stable while out_ready=0.
REQ-026 Handshake with out_last -> frame_done one-cycle pulse, state LOAD next cycle.
REQ-027 busy = (state!=LOAD) | (load counter!=0).
REQ-028 Counter widths ROWWIDTH; no wrap beyond ROWDEPTH-1.

Reset
REQ-029 rst=1 in any cycle/state: next cycle state=LOAD, all counters, outstanding count, valid shift register and FIFO cleared; in-flight read data discarded.
REQ-030 Post-reset values: in_ready=1, loaden=1, lmem_wr_en=0, start=0, hd_rd_en=0, out_valid=0, out_last=0, busy=0, frame_done=0, frame_err=0; address/data outputs 0.

Structure
REQ-031 Shared package ne_dec_pkg holds ROWDEPTH, ROWWIDTH, DW, MEMRDCYCLES and the state encoding.
REQ-032 Single sub-module ne_skid_fifo (synchronous FIFO, FIFO_DEPTH x DW, count output, sync active-high reset).

Verification
REQ-033 20 back-to-back beats, in_last on beat 19 -> writes addr 0..19 on cycles 1..20, start pulse cycle 21, loaden=0 from cycle 21.
REQ-034 in_last on beat 5 -> frame_err pulse, no start, next 20 beats load normally from addr 0.
REQ-035 SISOready 40 cycles after start, out_ready=1 -> 20 output beats consecutive, out_last on 20th, frame_done next cycle, in_ready=1.
REQ-036 out_ready toggled 1-of-3 during UNLOAD -> no lost/duplicate rows, data stable under stall, outstanding+count never > FIFO_DEPTH.
REQ-037 rst during UNLOAD with 2 reads in flight -> no out_valid afterward, state LOAD, stale hd_rd_data ignored.
